// File: rtl/icb_line_word_responder_pkg.sv
// Shared definitions for the ICB line/word responder: FSM states, line
// geometry and the default window base address.
package icb_line_word_responder_pkg;

  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned WIDX_W         = 3;
  localparam int unsigned LINE_OFF_W     = 5;
  localparam logic [31:0] DEF_BASE_ADDR  = 32'h2000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LREQ  = 3'd1,
    ST_LWAIT = 3'd2,
    ST_WREQ  = 3'd3,
    ST_WWAIT = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // Select one 32-bit word out of a 256-bit line.
  function automatic logic [31:0] line_word(input logic [255:0] line,
                                            input logic [WIDX_W-1:0] widx);
    return line[{widx, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/icb_lwr_line_buf.sv
// Single-line buffer: tag, valid, 256 data bits, hit compare, word select
// and byte-masked word update for write-through hits.
module icb_lwr_line_buf
  import icb_line_word_responder_pkg::*;
#(
  parameter int unsigned TAG_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  input  logic [WIDX_W-1:0] lookup_widx_i,
  output logic              hit_o,
  output logic [31:0]       rdata_o,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [255:0]      fill_data_i,
  input  logic              upd_i,
  input  logic [WIDX_W-1:0] upd_widx_i,
  input  logic [31:0]       upd_wdata_i,
  input  logic [3:0]        upd_wmask_i
);

  logic              vld_q;
  logic [TAG_W-1:0]  tag_q;
  logic [255:0]      data_q;

  // Hit compare and word select for the command being decoded.
  always_comb begin
    hit_o   = vld_q && (tag_q == lookup_tag_i);
    rdata_o = line_word(data_q, lookup_widx_i);
  end

  // Line fill from the backing port, or byte-masked update on a write hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (fill_i) begin
      vld_q  <= 1'b1;
      tag_q  <= fill_tag_i;
      data_q <= fill_data_i;
    end else if (upd_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (upd_wmask_i[i]) begin
          data_q[{upd_widx_i, 5'd0} + 8*i +: 8] <= upd_wdata_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/icb_line_word_responder.sv
// ICB word responder backed by a 256-bit line port. Keeps one line buffer so
// word reads within a fetched line are served without a line access; writes
// go through to the line port without allocating.
// Optional macro ICB_LINE_WORD_RESPONDER_STATS_EN adds hit/miss/write counters.
module icb_line_word_responder
  import icb_line_word_responder_pkg::*;
#(
  parameter int unsigned ALL_ADDR_LEN = 24,
  parameter int unsigned LINE_DW      = 256,
  parameter int unsigned LINE_MW      = 32,
  parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_icb_cmd_valid,
  output logic                    i_icb_cmd_ready,
  input  logic [31:0]             i_icb_cmd_addr,
  input  logic                    i_icb_cmd_read,
  input  logic [31:0]             i_icb_cmd_wdata,
  input  logic [3:0]              i_icb_cmd_wmask,
  output logic                    i_icb_rsp_valid,
  input  logic                    i_icb_rsp_ready,
  output logic [31:0]             i_icb_rsp_rdata,
  output logic                    i_icb_rsp_err,
  output logic                    line_cmd_valid,
  input  logic                    line_cmd_ready,
  output logic                    line_cmd_read,
  output logic [ALL_ADDR_LEN-1:0] line_cmd_addr,
  output logic [LINE_DW-1:0]      line_cmd_wdata,
  output logic [LINE_MW-1:0]      line_cmd_wmask,
  input  logic                    line_rsp_valid,
  output logic                    line_rsp_ready,
  input  logic [LINE_DW-1:0]      line_rsp_rdata
`ifdef ICB_LINE_WORD_RESPONDER_STATS_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt,
  output logic [31:0]             wr_cnt
`endif
);

  localparam int unsigned TAG_W = ALL_ADDR_LEN - LINE_OFF_W;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q;
  logic [WIDX_W-1:0] widx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wmask_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0]       off;
  logic              in_win;
  logic [TAG_W-1:0]  dec_tag;
  logic [WIDX_W-1:0] dec_widx;
  logic              accept;
  logic              buf_hit;
  logic [31:0]       buf_rdata;
  logic              buf_fill;
  logic              buf_upd;

  // Window decode of the incoming command address.
  always_comb begin
    off      = i_icb_cmd_addr - BASE_ADDR;
    in_win   = (off >> ALL_ADDR_LEN) == 32'd0;
    dec_tag  = off[ALL_ADDR_LEN-1:LINE_OFF_W];
    dec_widx = off[LINE_OFF_W-1:2];
    accept   = i_icb_cmd_valid && (state_q == ST_IDLE);
  end

  icb_lwr_line_buf #(
    .TAG_W (TAG_W)
  ) u_line_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_tag_i  (dec_tag),
    .lookup_widx_i (dec_widx),
    .hit_o         (buf_hit),
    .rdata_o       (buf_rdata),
    .fill_i        (buf_fill),
    .fill_tag_i    (tag_q),
    .fill_data_i   (line_rsp_rdata),
    .upd_i         (buf_upd),
    .upd_widx_i    (dec_widx),
    .upd_wdata_i   (i_icb_cmd_wdata),
    .upd_wmask_i   (i_icb_cmd_wmask)
  );

  // Next-state and buffer strobes; a write hit updates the buffer on accept.
  always_comb begin
    state_d  = state_q;
    buf_fill = 1'b0;
    buf_upd  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_win) begin
            state_d = ST_RESP;
          end else if (i_icb_cmd_read) begin
            state_d = buf_hit ? ST_RESP : ST_LREQ;
          end else begin
            state_d = ST_WREQ;
            buf_upd = buf_hit;
          end
        end
      end
      ST_LREQ:  if (line_cmd_ready) state_d = ST_LWAIT;
      ST_LWAIT: begin
        if (line_rsp_valid) begin
          buf_fill = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_WREQ:  if (line_cmd_ready) state_d = ST_WWAIT;
      ST_WWAIT: if (line_rsp_valid) state_d = ST_RESP;
      ST_RESP:  if (i_icb_rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Command capture and response data; rdata is 0 unless a read fills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      widx_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      tag_q       <= dec_tag;
      widx_q      <= dec_widx;
      wdata_q     <= i_icb_cmd_wdata;
      wmask_q     <= i_icb_cmd_wmask;
      rsp_err_q   <= !in_win;
      rsp_rdata_q <= (in_win && i_icb_cmd_read && buf_hit) ? buf_rdata : '0;
    end else if (buf_fill) begin
      rsp_rdata_q <= line_word(line_rsp_rdata, widx_q);
    end
  end

  // Handshake and line-port outputs, all derived from registered state.
  always_comb begin
    i_icb_cmd_ready = (state_q == ST_IDLE);
    i_icb_rsp_valid = (state_q == ST_RESP);
    i_icb_rsp_rdata = rsp_rdata_q;
    i_icb_rsp_err   = rsp_err_q;
    line_cmd_valid  = (state_q == ST_LREQ) || (state_q == ST_WREQ);
    line_cmd_read   = (state_q == ST_LREQ);
    line_cmd_addr   = {tag_q, {LINE_OFF_W{1'b0}}};
    line_cmd_wdata  = {WORDS_PER_LINE{wdata_q}};
    line_cmd_wmask  = '0;
    line_cmd_wmask[{widx_q, 2'b00} +: 4] = wmask_q;
    line_rsp_ready  = (state_q == ST_LWAIT) || (state_q == ST_WWAIT);
  end

`ifdef ICB_LINE_WORD_RESPONDER_STATS_EN
  // Per-accept classification counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wr_cnt   <= '0;
    end else if (accept && in_win) begin
      if (!i_icb_cmd_read)  wr_cnt   <= wr_cnt + 32'd1;
      else if (buf_hit)     hit_cnt  <= hit_cnt + 32'd1;
      else                  miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
